// File: rtl/rv_elastic_buffer_pkg.sv
// rtl/rv_elastic_buffer_pkg.sv - shared constants, helpers and beat type for the elastic buffer
`ifndef RV_BEAT_T
`define RV_BEAT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }
`endif

package rv_elastic_buffer_pkg;

    localparam int RV_DFLT_DATA_W = 8;
    localparam int RV_DFLT_DEPTH  = 2;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef `RV_BEAT_T(RV_DFLT_DATA_W) rv_beat_t;

endpackage

// File: rtl/rv_elastic_buffer_if.sv
// rtl/rv_elastic_buffer_if.sv - ready/valid stream interface with master/slave modports
interface rv_if
    import rv_elastic_buffer_pkg::*;
#(
    parameter int DATA_W = RV_DFLT_DATA_W
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rv_elastic_buffer_core.sv
// rtl/rv_elastic_buffer_core.sv - flat-port elastic buffer: flop storage, level, flush, protocol checker
module rv_elastic_buffer_core
    import rv_elastic_buffer_pkg::*;
#(
    parameter int DATA_W    = RV_DFLT_DATA_W,
    parameter int DEPTH     = RV_DFLT_DEPTH,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [DATA_W-1:0]         i_data,
    output logic                      e_valid,
    input  logic                      e_ready,
    output logic [DATA_W-1:0]         e_data,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      almost_full,
    output logic                      proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rv_elastic_buffer: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("rv_elastic_buffer: AF_THRESH must be within 1..DEPTH");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("rv_elastic_buffer: DATA_W must be >= 1");
    end

    typedef `RV_BEAT_T(DATA_W) beat_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              proto_err_q;
    beat_t             pend_q;
    logic              push;
    logic              pop;

    // Handshake outputs depend only on registered level (plus flush), never on the far side's handshake.
    assign i_ready     = (level_q != FULL_LVL) & ~flush;
    assign e_valid     = (level_q != '0);
    assign e_data      = mem[rd_ptr];
    assign level       = level_q;
    assign almost_full = (level_q >= AF_LVL);
    assign proto_err   = proto_err_q;

    assign push = i_valid & i_ready;
    assign pop  = e_valid & e_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            proto_err_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            // A stalled offer must be held unchanged until it is accepted.
            if (pend_q.valid && (!i_valid || i_data != pend_q.data)) begin
                proto_err_q <= 1'b1;
            end
            pend_q.valid <= i_valid & ~i_ready & ~flush;
            pend_q.data  <= i_data;

            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   level_q <= level_q + LVL_W'(1);
                    2'b01:   level_q <= level_q - LVL_W'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/rv_elastic_buffer.sv
// rtl/rv_elastic_buffer.sv - elastic buffer top exposing ingress/egress as rv_if modports
module rv_elastic_buffer
    import rv_elastic_buffer_pkg::*;
#(
    parameter int DATA_W    = RV_DFLT_DATA_W,
    parameter int DEPTH     = RV_DFLT_DEPTH,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    rv_if.slave                     rv_i,
    rv_if.master                    rv_e,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    almost_full,
    output logic                    proto_err
);
    rv_elastic_buffer_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .i_valid     (rv_i.valid),
        .i_ready     (rv_i.ready),
        .i_data      (rv_i.data),
        .e_valid     (rv_e.valid),
        .e_ready     (rv_e.ready),
        .e_data      (rv_e.data),
        .level       (level),
        .almost_full (almost_full),
        .proto_err   (proto_err)
    );
endmodule

// File: tb/tb_rv_elastic_buffer.sv
// tb/tb_rv_elastic_buffer.sv - directed and randomized checks of rv_elastic_buffer at DEPTH 2, 4 and 8
module tb_rv_elastic_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush2, flush4, flush8;
    logic [1:0] level2;
    logic [2:0] level4;
    logic [3:0] level8;
    logic af2, af4, af8, pe2, pe4, pe8;
    int total = 0;
    int bad   = 0;

    rv_if #(.DATA_W(8))  i2 ();
    rv_if #(.DATA_W(8))  e2 ();
    rv_if #(.DATA_W(8))  i4 ();
    rv_if #(.DATA_W(8))  e4 ();
    rv_if #(.DATA_W(32)) i8 ();
    rv_if #(.DATA_W(32)) e8 ();

    rv_elastic_buffer #(.DATA_W(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .rv_i(i2), .rv_e(e2),
        .level(level2), .almost_full(af2), .proto_err(pe2));
    rv_elastic_buffer #(.DATA_W(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .rv_i(i4), .rv_e(e4),
        .level(level4), .almost_full(af4), .proto_err(pe4));
    rv_elastic_buffer #(.DATA_W(32), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush8), .rv_i(i8), .rv_e(e8),
        .level(level8), .almost_full(af8), .proto_err(pe8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        total++; if ({i2.ready, e2.valid, level2, af2, pe2} !== 6'b100000) begin bad++; $display("FAIL reset_dut2 got=%b exp=100000", {i2.ready, e2.valid, level2, af2, pe2}); end
        total++; if ({i4.ready, e4.valid, level4, af4, pe4} !== 7'b1000000) begin bad++; $display("FAIL reset_dut4 got=%b exp=1000000", {i4.ready, e4.valid, level4, af4, pe4}); end
        total++; if ({i8.ready, e8.valid, level8, af8, pe8} !== 8'b10000000) begin bad++; $display("FAIL reset_dut8 got=%b exp=10000000", {i8.ready, e8.valid, level8, af8, pe8}); end
        tick();
    endtask

    task automatic test_back_to_back();
        e2.ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            i2.valid = (k < 16);
            i2.data  = 8'(k + 1);
            #1;
            if (k == 0 || k == 17) begin
                total++; if (e2.valid !== 1'b0) begin bad++; $display("FAIL b2b_evalid_idle k=%0d got=%b exp=0", k, e2.valid); end
            end else begin
                total++; if (e2.valid !== 1'b1 || e2.data !== 8'(k)) begin bad++; $display("FAIL b2b_data k=%0d got=%b/%h exp=1/%h", k, e2.valid, e2.data, 8'(k)); end
            end
            if (k < 16) begin
                total++; if (i2.ready !== 1'b1) begin bad++; $display("FAIL b2b_iready k=%0d got=%b exp=1", k, i2.ready); end
            end
            tick();
        end
        e2.ready = 1'b0;
        i2.valid = 1'b0;
    endtask

    task automatic test_fill_drain();
        int  exp;
        bit  sent5;
        e4.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i4.valid = 1'b1;
            i4.data  = 8'((c < 4) ? c + 1 : 5);
            #1;
            total++; if (level4 !== 3'(c) || af4 !== (c >= 3) || i4.ready !== (c < 4)) begin bad++; $display("FAIL fill c=%0d got lvl=%0d af=%b rdy=%b exp lvl=%0d af=%b rdy=%b", c, level4, af4, i4.ready, c, (c >= 3), (c < 4)); end
            tick();
        end
        exp   = 1;
        sent5 = 1'b0;
        e4.ready = 1'b1;
        for (int n = 0; n < 20 && exp <= 5; n++) begin
            i4.valid = !sent5;
            i4.data  = 8'd5;
            #1;
            if (e4.valid) begin
                total++; if (e4.data !== 8'(exp)) begin bad++; $display("FAIL drain_order got=%h exp=%h", e4.data, 8'(exp)); end
                exp++;
            end
            if (i4.valid && i4.ready) sent5 = 1'b1;
            tick();
        end
        i4.valid = 1'b0;
        e4.ready = 1'b0;
        #1;
        total++; if (exp !== 6) begin bad++; $display("FAIL drain_count got=%0d exp=6", exp - 1); end
        total++; if (level4 !== 3'd0 || e4.valid !== 1'b0) begin bad++; $display("FAIL drain_empty got lvl=%0d ev=%b exp lvl=0 ev=0", level4, e4.valid); end
        total++; if (pe4 !== 1'b0) begin bad++; $display("FAIL drain_proto got=%b exp=0", pe4); end
        tick();
    endtask

    task automatic test_full_pop_push();
        e4.ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i4.valid = 1'b1;
            i4.data  = 8'(8'hA1 + c);
            tick();
        end
        i4.data  = 8'hA5;
        e4.ready = 1'b1;
        #1;
        total++; if (i4.ready !== 1'b0 || level4 !== 3'd4 || e4.data !== 8'hA1) begin bad++; $display("FAIL full_pop got rdy=%b lvl=%0d d=%h exp rdy=0 lvl=4 d=a1", i4.ready, level4, e4.data); end
        tick();
        e4.ready = 1'b0;
        #1;
        total++; if (i4.ready !== 1'b1 || level4 !== 3'd3) begin bad++; $display("FAIL after_pop got rdy=%b lvl=%0d exp rdy=1 lvl=3", i4.ready, level4); end
        tick();
        i4.valid = 1'b0;
        #1;
        total++; if (i4.ready !== 1'b0 || level4 !== 3'd4) begin bad++; $display("FAIL refill got rdy=%b lvl=%0d exp rdy=0 lvl=4", i4.ready, level4); end
        e4.ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            total++; if (e4.valid !== 1'b1 || e4.data !== 8'(8'hA2 + j)) begin bad++; $display("FAIL full_drain j=%0d got=%b/%h exp=1/%h", j, e4.valid, e4.data, 8'(8'hA2 + j)); end
            tick();
        end
        e4.ready = 1'b0;
        #1;
        total++; if (level4 !== 3'd0) begin bad++; $display("FAIL full_drain_lvl got=%0d exp=0", level4); end
    endtask

    task automatic test_flush();
        e4.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i4.valid = 1'b1;
            i4.data  = 8'(8'hB1 + c);
            tick();
        end
        flush4   = 1'b1;
        e4.ready = 1'b1;
        i4.data  = 8'hB4;
        #1;
        total++; if (i4.ready !== 1'b0 || e4.valid !== 1'b1 || e4.data !== 8'hB1 || level4 !== 3'd3 || af4 !== 1'b1) begin bad++; $display("FAIL flush_cycle got rdy=%b ev=%b d=%h lvl=%0d af=%b exp 0 1 b1 3 1", i4.ready, e4.valid, e4.data, level4, af4); end
        tick();
        flush4   = 1'b0;
        i4.valid = 1'b0;
        e4.ready = 1'b0;
        #1;
        total++; if (level4 !== 3'd0 || e4.valid !== 1'b0 || i4.ready !== 1'b1) begin bad++; $display("FAIL post_flush got lvl=%0d ev=%b rdy=%b exp 0 0 1", level4, e4.valid, i4.ready); end
        tick();
        total++; if (pe4 !== 1'b0) begin bad++; $display("FAIL flush_pending got=%b exp=0", pe4); end
    endtask

    task automatic test_proto_err();
        e2.ready = 1'b0;
        i2.valid = 1'b1; i2.data = 8'hC1; tick();
        i2.data  = 8'hC2; tick();
        i2.data  = 8'hC3;
        #1;
        total++; if (i2.ready !== 1'b0 || level2 !== 2'd2 || af2 !== 1'b1) begin bad++; $display("FAIL pe_full got rdy=%b lvl=%0d af=%b exp 0 2 1", i2.ready, level2, af2); end
        tick();
        i2.valid = 1'b0;
        #1;
        total++; if (pe2 !== 1'b0) begin bad++; $display("FAIL pe_early got=%b exp=0", pe2); end
        tick();
        total++; if (pe2 !== 1'b1) begin bad++; $display("FAIL pe_drop got=%b exp=1", pe2); end
        flush2 = 1'b1;
        tick();
        flush2 = 1'b0;
        #1;
        total++; if (pe2 !== 1'b1 || level2 !== 2'd0) begin bad++; $display("FAIL pe_sticky got pe=%b lvl=%0d exp 1 0", pe2, level2); end
        i2.valid = 1'b1; i2.data = 8'hC4;
        tick();
        rst = 1'b1; i2.data = 8'hC5;
        tick();
        rst = 1'b0; i2.valid = 1'b0;
        #1;
        total++; if (pe2 !== 1'b0 || level2 !== 2'd0 || e2.valid !== 1'b0) begin bad++; $display("FAIL pe_reset got pe=%b lvl=%0d ev=%b exp 0 0 0", pe2, level2, e2.valid); end
        i2.valid = 1'b1; i2.data = 8'hD1; tick();
        i2.data  = 8'hD2; tick();
        i2.data  = 8'hD3; tick();
        i2.data  = 8'hD4; tick();
        i2.valid = 1'b0;
        total++; if (pe2 !== 1'b1) begin bad++; $display("FAIL pe_data_change got=%b exp=1", pe2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (pe2 !== 1'b0 || level2 !== 2'd0) begin bad++; $display("FAIL pe_clear got pe=%b lvl=%0d exp 0 0", pe2, level2); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        bit          blocked;
        int          sz;
        int          pr;
        int          pv;
        blocked = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pr = (cyc < 1000) ? 20 : (cyc < 2000) ? 85 : 50;
            pv = (cyc < 1000) ? 80 : (cyc < 2000) ? 30 : 60;
            if (!blocked) begin
                i8.valid = ($urandom_range(0, 99) < pv);
                i8.data  = $urandom;
            end
            e8.ready = ($urandom_range(0, 99) < pr);
            #1;
            sz = q.size();
            total++; if (level8 !== 4'(sz)) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, level8, sz); end
            total++; if (e8.valid !== (sz != 0) || i8.ready !== (sz != 8) || af8 !== (sz >= 7)) begin bad++; $display("FAIL rnd_flags cyc=%0d got ev=%b rdy=%b af=%b sz=%0d", cyc, e8.valid, i8.ready, af8, sz); end
            if (sz != 0) begin
                total++; if (e8.data !== q[0]) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, e8.data, q[0]); end
                if (e8.ready) void'(q.pop_front());
            end
            if (i8.valid && sz != 8) q.push_back(i8.data);
            blocked = i8.valid && (sz == 8);
            tick();
        end
        i8.valid = 1'b0;
        e8.ready = 1'b0;
        #1;
        total++; if (pe8 !== 1'b0) begin bad++; $display("FAIL rnd_proto got=%b exp=0", pe8); end
    endtask

    initial begin
        rst = 1'b1;
        flush2 = 1'b0; flush4 = 1'b0; flush8 = 1'b0;
        i2.valid = 1'b0; i2.data = '0; e2.ready = 1'b0;
        i4.valid = 1'b0; i4.data = '0; e4.ready = 1'b0;
        i8.valid = 1'b0; i8.data = '0; e8.ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_fill_drain();
        test_full_pop_push();
        test_flush();
        test_proto_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
